// File: rtl/wam_pkg.sv
// -----------------------------------------------------------------------------
// wam_pkg
// Shared types and helpers for the Whac-A-Mole mole scheduler.
//   state_t  : scheduler FSM states (IDLE, LOAD, RUN)
//   hidx_w   : number of LFSR bits needed to address a hole
//   popcount : number of set bits in a hole vector (up to 16 holes)
// -----------------------------------------------------------------------------
package wam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Hole index width; a single-hole build still needs one index bit.
    function automatic int hidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int popcount(input logic [15:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/wam_lfsr.sv
// -----------------------------------------------------------------------------
// wam_lfsr
// Galois LFSR used as the mole-position random source.
// Bit 0 takes the msb; every other bit k takes bit k-1, XORed with the msb
// when LFSR_TAPS[k] is set. Default parameters reproduce the team's 8-bit
// generator.
// Ports:
//   clk   in  1       clock
//   clr   in  1       asynchronous active-low reset (register -> 0)
//   load  in  1       load seed (has priority over en)
//   seed  in  LFSR_W  value loaded on load
//   en    in  1       advance one step
//   num   out LFSR_W  current LFSR state
// -----------------------------------------------------------------------------
module wam_lfsr #(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'h54
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              en,
    output logic [LFSR_W-1:0] num
);

    logic [LFSR_W-1:0] nxt;

    always_comb begin
        nxt    = '0;
        nxt[0] = num[LFSR_W-1];
        for (int k = 1; k < LFSR_W; k++) begin
            nxt[k] = num[k-1] ^ (LFSR_TAPS[k] & num[LFSR_W-1]);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            num <= '0;
        end else if (load) begin
            num <= seed;
        end else if (en) begin
            num <= nxt;
        end
    end

endmodule

// File: rtl/wam_mole_sched.sv
// -----------------------------------------------------------------------------
// wam_mole_sched
// Mole scheduler for Whac-A-Mole: spawns moles in pseudo-random holes at a
// programmable tick interval, ages each raised mole and retires it on a hit or
// on timeout. All outputs are registered (one clk after the hit/tick).
// Optional feature macro: WAM_PAUSE_EN adds a 'pause' input that freezes tick
// effects and hits while in RUN (LFSR keeps running, moles hold).
// Ports:
//   clk        in   1        clock
//   clr        in   1        asynchronous active-low reset
//   tick       in   1        game-rate enable, one clk wide
//   start      in   1        load seed and enter RUN (via LOAD)
//   stop       in   1        drop all moles, enter IDLE (beats start)
//   seed       in   LFSR_W   LFSR seed, sampled on start (0 -> 1)
//   life_max   in   LIFE_W   mole lifetime in ticks (0 -> 1)
//   spawn_gap  in   GAP_W    ticks between spawn attempts (0 -> 1)
//   hit        in   N_HOLES  per-hole button pulses
//   pause      in   1        (WAM_PAUSE_EN only) freeze game in RUN
//   mole       out  N_HOLES  raised moles
//   hit_ok     out  1        a raised mole was whacked
//   hit_mask   out  N_HOLES  holes whacked (valid with hit_ok)
//   whiff      out  1        a hit landed on an empty hole
//   escape     out  1        at least one mole timed out
//   running    out  1        scheduler is in RUN
// -----------------------------------------------------------------------------
module wam_mole_sched
    import wam_pkg::*;
#(
    parameter int                N_HOLES   = 8,
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'h54,
    parameter int                LIFE_W    = 4,
    parameter int                GAP_W     = 4,
    parameter int                MAX_UP    = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [LIFE_W-1:0]  life_max,
    input  logic [GAP_W-1:0]   spawn_gap,
    input  logic [N_HOLES-1:0] hit,
`ifdef WAM_PAUSE_EN
    input  logic               pause,
`endif
    output logic [N_HOLES-1:0] mole,
    output logic               hit_ok,
    output logic [N_HOLES-1:0] hit_mask,
    output logic               whiff,
    output logic               escape,
    output logic               running
);

    localparam int HIDX_W = hidx_w(N_HOLES);

    state_t             state;
    logic [GAP_W-1:0]   gap;
    logic [LIFE_W-1:0]  life [N_HOLES];
    logic [LFSR_W-1:0]  lfsr_num;
    logic [LFSR_W-1:0]  seed_eff;
    logic [LIFE_W-1:0]  life_eff;
    logic [GAP_W-1:0]   gap_eff;
    logic               live;
    logic               tick_live;
    logic               gap_due;
    logic               room;
    logic               whiff_now;
    logic [HIDX_W-1:0]  spawn_idx;
    logic [N_HOLES-1:0] hit_now;
    logic [N_HOLES-1:0] expire;
    logic [N_HOLES-1:0] spawn_vec;
    logic               unused_lfsr_bits;

    // Zero seed would lock the LFSR; zero life/gap behave as one tick.
    assign seed_eff = (seed == '0) ? LFSR_W'(1) : seed;
    assign life_eff = (life_max == '0) ? LIFE_W'(1) : life_max;
    assign gap_eff  = (spawn_gap == '0) ? GAP_W'(1) : spawn_gap;

`ifdef WAM_PAUSE_EN
    assign live = (state == RUN) && !pause;
`else
    assign live = (state == RUN);
`endif

    // Only the low bits pick the hole; the rest feed the sequence only.
    assign unused_lfsr_bits = ^lfsr_num;

    wam_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk  (clk),
        .clr  (clr),
        .load ((state == IDLE) && start && !stop),
        .seed (seed_eff),
        .en   (state == RUN),
        .num  (lfsr_num)
    );

    // Per-cycle game events, all judged against the pre-edge mole vector so a
    // hole whacked or expiring this cycle cannot be refilled in the same cycle.
    always_comb begin
        hit_now   = live ? (hit & mole) : '0;
        whiff_now = live && (|(hit & ~mole));
        tick_live = live && tick;
        gap_due   = (gap <= GAP_W'(1));
        room      = popcount(16'(mole)) < MAX_UP;
        spawn_idx = lfsr_num[HIDX_W-1:0];
        spawn_vec = '0;
        if (tick_live && gap_due && !mole[spawn_idx] && room) begin
            spawn_vec[spawn_idx] = 1'b1;
        end
        expire = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            expire[i] = tick_live && mole[i] && !hit_now[i] && (life[i] == LIFE_W'(1));
        end
    end

    // Scheduler FSM with all game state and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            gap      <= '0;
            mole     <= '0;
            hit_ok   <= 1'b0;
            hit_mask <= '0;
            whiff    <= 1'b0;
            escape   <= 1'b0;
            running  <= 1'b0;
            for (int i = 0; i < N_HOLES; i++) begin
                life[i] <= '0;
            end
        end else begin
            hit_ok   <= 1'b0;
            hit_mask <= '0;
            whiff    <= 1'b0;
            escape   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    gap     <= gap_eff;
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        mole    <= '0;
                        gap     <= '0;
                        for (int i = 0; i < N_HOLES; i++) begin
                            life[i] <= '0;
                        end
                    end else begin
                        hit_ok   <= |hit_now;
                        hit_mask <= hit_now;
                        whiff    <= whiff_now;
                        escape   <= |expire;
                        mole     <= (mole & ~hit_now & ~expire) | spawn_vec;
                        if (tick_live) begin
                            gap <= gap_due ? gap_eff : gap - GAP_W'(1);
                        end
                        for (int i = 0; i < N_HOLES; i++) begin
                            if (spawn_vec[i]) begin
                                life[i] <= life_eff;
                            end else if (hit_now[i] || expire[i]) begin
                                life[i] <= '0;
                            end else if (tick_live && mole[i]) begin
                                life[i] <= life[i] - LIFE_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
